univ_shift_reg: RTL and testbench

Parametrised universal register: the successor to the fixed 4-bit load/shift register and the 5-bit ripple pulse counter. It merges both into one synchronous WIDTH-bit datapath with eight modes: hold, load, shift/rotate in both directions, and up/down count. It adds a self-timed burst-serialiser with a busy/done handshake. It sits between the datapath registers and serial I/O, and is used as a counter, a shifter or a serial transmitter.

---
 rtl/usr_pkg.sv | 23 ++
 rtl/univ_shift_reg.sv | 103 ++++++++++
 tb/tb_univ_shift_reg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift/count register.
//   MODE_*   : 3-bit operation select codes driven on the mode port
//   st_e     : burst serialiser states
//   cnt_w()  : width of the burst bit counter for a given register width
package usr_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'd0;
  localparam logic [2:0] MODE_LOAD   = 3'd1;
  localparam logic [2:0] MODE_SHR    = 3'd2;
  localparam logic [2:0] MODE_SHL    = 3'd3;
  localparam logic [2:0] MODE_ROR    = 3'd4;
  localparam logic [2:0] MODE_ROL    = 3'd5;
  localparam logic [2:0] MODE_CNT_UP = 3'd6;
  localparam logic [2:0] MODE_CNT_DN = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} st_e;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/count modes plus a
// self-timed burst serialiser that shifts a loaded word out LSB first.
// Ports:
//   clk, r        : clock, asynchronous active-low reset
//   en, mode      : mode enable and operation select (idle only)
//   value         : parallel data for LOAD and burst start
//   sin_r, sin_l  : serial inputs entering at MSB (right shift) / LSB (left)
//   start         : burst request, sampled only while idle
//   q, sout       : register contents, serial out (= q[0])
//   tc            : terminal count flag, combinational from q and mode
//   busy, done    : burst in progress, one-cycle completion pulse
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] value,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  st_e             st;
  logic [CW-1:0]   bitcnt;
  logic [WIDTH-1:0] mode_nxt;

  // Next q for the idle-mode operations.
  always_comb begin
    mode_nxt = q;
    case (mode)
      MODE_HOLD:   mode_nxt = q;
      MODE_LOAD:   mode_nxt = value;
      MODE_SHR:    mode_nxt = {sin_r, q[WIDTH-1:1]};
      MODE_SHL:    mode_nxt = {q[WIDTH-2:0], sin_l};
      MODE_ROR:    mode_nxt = {q[0], q[WIDTH-1:1]};
      MODE_ROL:    mode_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_CNT_UP: mode_nxt = q + WIDTH'(1);
      MODE_CNT_DN: mode_nxt = q - WIDTH'(1);
      default:     mode_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      q      <= '0;
      st     <= ST_IDLE;
      bitcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          done <= 1'b0;
          // start outranks mode/en in the same cycle
          if (start) begin
            q      <= value;
            bitcnt <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            st     <= ST_SHIFT;
          end else if (en) begin
            q <= mode_nxt;
          end
        end
        ST_SHIFT: begin
          q <= {sin_r, q[WIDTH-1:1]};
          // bitcnt==0 marks the last of WIDTH shifts
          if (bitcnt == '0) begin
            busy <= 1'b0;
            done <= 1'b1;
            st   <= ST_DONE;
          end else begin
            bitcnt <= bitcnt - CW'(1);
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

  assign sout = q[0];
  assign tc   = ((mode == MODE_CNT_UP) && (&q)) ||
                ((mode == MODE_CNT_DN) && (q == '0));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: each cycle the driver applies inputs, pushes the
// outputs the reference model expects at the following falling edge, then
// advances the model across the next rising edge. A monitor pops and
// compares on every falling edge.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         r, en, sin_r, sin_l, start;
  logic [2:0]   mode;
  logic [W-1:0] value;
  logic [W-1:0] q;
  logic         sout, tc, busy, done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .r(r), .en(en), .mode(mode), .value(value),
    .sin_r(sin_r), .sin_l(sin_l), .start(start),
    .q(q), .sout(sout), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    bit busy, done, sout, tc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a register value, shifts left in the burst, and a
  // pending-done flag.
  int unsigned m_q;
  int          m_left;
  bit          m_done;

  function automatic int unsigned apply_mode(input int unsigned v, input int md,
                                             input bit sr, input bit sl,
                                             input int unsigned ld);
    case (md)
      0: return v;
      1: return ld & MASK;
      2: return (v >> 1) | (int'(sr) << (W - 1));
      3: return ((v << 1) | sl) & MASK;
      4: return (v >> 1) | ((v & 1) << (W - 1));
      5: return ((v << 1) & MASK) | (v >> (W - 1));
      6: return (v + 1) & MASK;
      default: return (v + MASK) & MASK;
    endcase
  endfunction

  task automatic step(input bit rr, input bit e, input int md, input int unsigned v,
                      input bit sr, input bit sl, input bit st);
    obs_t o;
    @(posedge clk);
    #1;
    r = rr; en = e; mode = 3'(md); value = W'(v); sin_r = sr; sin_l = sl; start = st;
    if (!rr) begin
      m_q = 0; m_left = 0; m_done = 0;
    end
    o.q    = m_q;
    o.busy = (m_left > 0);
    o.done = m_done;
    o.sout = m_q[0];
    o.tc   = (md == 6 && m_q == MASK) || (md == 7 && m_q == 0);
    exp_q.push_back(o);
    if (rr) begin
      if (m_left > 0) begin
        m_q = (m_q >> 1) | (int'(sr) << (W - 1));
        m_left--;
        m_done = (m_left == 0);
      end else if (m_done) begin
        m_done = 0;
      end else if (st) begin
        m_q = v & MASK;
        m_left = W;
      end else if (e) begin
        m_q = apply_mode(m_q, md, sr, sl, v);
      end
    end
  endtask

  always @(negedge clk) begin
    obs_t o;
    if (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      n_cmp++;
      if (q !== W'(o.q) || busy !== o.busy || done !== o.done ||
          sout !== o.sout || tc !== o.tc) begin
        n_bad++;
        $display("FAIL cycle_out t=%0t got q=%h busy=%b done=%b sout=%b tc=%b exp q=%h busy=%b done=%b sout=%b tc=%b",
                 $time, q, busy, done, sout, tc, W'(o.q), o.busy, o.done, o.sout, o.tc);
      end
    end
  end

  initial begin
    r = 1'b0; en = 1'b0; mode = 3'd0; value = '0; sin_r = 1'b0; sin_l = 1'b0; start = 1'b0;
    m_q = 0; m_left = 0; m_done = 0;

    // reset with counting-down mode shows tc=1
    step(0, 0, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // load, then asynchronous reset mid-cycle
    step(1, 1, 1, 'hA5, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // shift / rotate
    step(1, 1, 1, 'h81, 0, 0, 0);
    step(1, 1, 2, 0, 1, 0, 0);
    step(1, 1, 5, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0);
    // counting and tc, wrap both ways, en low holds
    step(1, 1, 1, 'hFE, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0);
    step(1, 0, 7, 0, 0, 0, 0);
    step(1, 0, 6, 0, 0, 0, 0);
    // burst with start/LOAD noise during SHIFT and DONE
    step(1, 1, 0, 'h5A, 0, 0, 1);
    for (int i = 0; i < W + 1; i++) step(1, 1, 1, 'hFF, 0, 0, 1);
    // cycle after done: new burst accepted
    step(1, 0, 0, 'h3C, 1, 0, 1);
    for (int i = 0; i < W + 2; i++) step(1, 0, 0, 0, 1, 0, 0);
    // reset at burst bit 3, then a full burst
    step(1, 0, 0, 'hC3, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 'h96, 1, 0, 1);
    for (int i = 0; i < W + 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
           $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
